// File: rtl/debug_ocimem_ctrl_if.sv
// -----------------------------------------------------------------------------
// debug_ocimem_ctrl_if
// Bus bundle between the debug-slave stage, the OCI monitor-memory controller
// and the monitor RAM.
//   slave  modport : the controller (consumes commands, drives RAM + status)
//   master modport : the environment (debug-slave stage plus RAM read data)
// Signals:
//   jdo                     38-bit debug command word
//   take_action_ocimem_a    strobe: load address, optionally read
//   take_action_ocimem_b    strobe: write one data word
//   take_no_action_ocimem_a strobe: read next sequential word
//   debugack                CPU halted in debug; accesses legal only when high
//   MonDReg                 last read data
//   monitor_ready           last access has completed
//   monitor_error           sticky error flag
//   ram_addr/re/we/wdata    monitor RAM request side
//   ram_rdata               monitor RAM read data, one cycle after ram_re
// -----------------------------------------------------------------------------
interface debug_ocimem_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic [37:0]       jdo;
   logic              take_action_ocimem_a;
   logic              take_action_ocimem_b;
   logic              take_no_action_ocimem_a;
   logic              debugack;
   logic [31:0]       MonDReg;
   logic              monitor_ready;
   logic              monitor_error;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_re;
   logic              ram_we;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   modport slave (
      input  jdo, take_action_ocimem_a, take_action_ocimem_b,
             take_no_action_ocimem_a, debugack, ram_rdata,
      output MonDReg, monitor_ready, monitor_error,
             ram_addr, ram_re, ram_we, ram_wdata
   );

   modport master (
      output jdo, take_action_ocimem_a, take_action_ocimem_b,
             take_no_action_ocimem_a, debugack, ram_rdata,
      input  MonDReg, monitor_ready, monitor_error,
             ram_addr, ram_re, ram_we, ram_wdata
   );
endinterface

// File: rtl/debug_ocimem_ctrl.sv
// -----------------------------------------------------------------------------
// debug_ocimem_ctrl
// OCI monitor-memory access controller. Turns single-cycle debug strobes into
// monitor RAM reads/writes on a 2^ADDR_W x 32 RAM with 1-cycle read latency.
// Ports:
//   clk      single clock, all state is in this domain
//   reset_n  asynchronous active-low reset
//   bus      debug_ocimem_ctrl_if.slave (command strobes, status, RAM side)
// Sequencing (T = strobe cycle):
//   read : T+1 ram_re, T+2 capture ram_rdata, T+3 monitor_ready
//   write: T+1 ram_we + address post-increment, T+2 monitor_ready
// -----------------------------------------------------------------------------
module debug_ocimem_ctrl #(
   parameter int ADDR_W = 8
) (
   input logic               clk,
   input logic               reset_n,
   debug_ocimem_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_REQ  = 2'd1,
      RD_DATA = 2'd2,
      WR      = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state_q;
   logic [ADDR_W-1:0] mon_a_q;
   logic [ADDR_W-1:0] mon_a_inc_d;
   logic [31:0]       mon_d_q;
   logic [31:0]       wdata_q;
   logic              re_q;
   logic              we_q;
   logic              ready_q;
   logic              error_q;
   logic              strobe_any;
   logic              unused_jdo;

   assign strobe_any  = bus.take_action_ocimem_a | bus.take_action_ocimem_b |
                        bus.take_no_action_ocimem_a;
   // Natural wrap of the ADDR_W-bit adder gives the modulo-2^ADDR_W step.
   assign mon_a_inc_d = mon_a_q + ADDR_ONE;
   assign unused_jdo  = ^{bus.jdo[37:36], bus.jdo[2:0]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         mon_a_q <= '0;
         mon_d_q <= '0;
         wdata_q <= '0;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
         ready_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         // RAM enables are one-cycle pulses raised on the transition into
         // RD_REQ / WR, so they line up with those states.
         re_q <= 1'b0;
         we_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (strobe_any) begin
                  if (!bus.debugack) begin
                     // CPU not halted: refuse the access but complete at once.
                     error_q <= 1'b1;
                     ready_q <= 1'b1;
                  end else if (bus.take_action_ocimem_a) begin
                     mon_a_q <= bus.jdo[16+ADDR_W:17];
                     if (bus.jdo[34]) begin
                        state_q <= RD_REQ;
                        re_q    <= 1'b1;
                        ready_q <= 1'b0;
                     end else begin
                        ready_q <= 1'b1;
                     end
                  end else if (bus.take_action_ocimem_b) begin
                     wdata_q <= bus.jdo[34:3];
                     state_q <= WR;
                     we_q    <= 1'b1;
                     ready_q <= 1'b0;
                  end else begin
                     mon_a_q <= mon_a_inc_d;
                     state_q <= RD_REQ;
                     re_q    <= 1'b1;
                     ready_q <= 1'b0;
                  end
                  // Error clear wins over the debugack set above.
                  if (bus.take_action_ocimem_a && bus.jdo[35]) begin
                     error_q <= 1'b0;
                  end
               end
            end
            RD_REQ: begin
               state_q <= RD_DATA;
            end
            RD_DATA: begin
               mon_d_q <= bus.ram_rdata;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            WR: begin
               mon_a_q <= mon_a_inc_d;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
         // Strobes while busy are dropped; only the sticky flag records them.
         if ((state_q != IDLE) && strobe_any) begin
            error_q <= 1'b1;
         end
      end
   end

   assign bus.MonDReg       = mon_d_q;
   assign bus.monitor_ready = ready_q;
   assign bus.monitor_error = error_q;
   assign bus.ram_addr      = mon_a_q;
   assign bus.ram_re        = re_q;
   assign bus.ram_we        = we_q;
   assign bus.ram_wdata     = wdata_q;

endmodule
